// File: rtl/shift_stage_buffer.sv
// Execution-stage shifter wrapper. Each accepted command is shifted combinationally,
// and its result, destination and flags go into a small in-order FIFO that feeds
// writeback. The architectural flag register is updated when a flag-writing entry
// leaves the FIFO.
module shift_stage_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DEST_W = 5
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iFLUSH,
  input  logic              iPREVIOUS_VALID,
  output logic              oPREVIOUS_LOCK,
  input  logic [2:0]        iPREVIOUS_CMD,
  input  logic [31:0]       iPREVIOUS_DATA_0,
  input  logic [31:0]       iPREVIOUS_DATA_1,
  input  logic [DEST_W-1:0] iPREVIOUS_DESTINATION,
  input  logic              iPREVIOUS_FLAG_WRITE,
  output logic              oNEXT_VALID,
  input  logic              iNEXT_LOCK,
  output logic [31:0]       oNEXT_DATA,
  output logic [DEST_W-1:0] oNEXT_DESTINATION,
  output logic [4:0]        oNEXT_FLAGS,
  output logic              oNEXT_FLAG_WRITE,
  output logic [4:0]        oFLAGS_COMMIT,
  output logic [3:0]        oCOUNT
);

  localparam int unsigned     PtrW      = $clog2(DEPTH);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(DEPTH - 1);
  localparam logic [3:0]      FullCount = 4'(DEPTH);

  // FIFO storage, indexed by the wrapping pointers.
  logic [31:0]       data_q  [DEPTH];
  logic [DEST_W-1:0] dest_q  [DEPTH];
  logic [4:0]        flags_q [DEPTH];
  logic              fw_q    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]      count_q, count_d;
  logic [4:0]      flags_commit_q;

  logic full, not_empty, push, pop;

  // Shifter signals
  logic [5:0]        amt;
  logic [4:0]        rot;
  logic [32:0]       sll_w, srl_w;
  logic signed [32:0] sra_w;
  logic [31:0]       rol_res, ror_res;
  logic [31:0]       sh_res;
  logic              sh_cf;
  logic [4:0]        sh_flags;

  // Only the low six bits of the amount operand are meaningful.
  logic unused_amt_bits;
  assign unused_amt_bits = ^iPREVIOUS_DATA_1[31:6];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full      = (count_q == FullCount);
  assign not_empty = (count_q != 4'd0);
  // A full FIFO refuses pushes even when it pops in the same cycle (no bypass).
  assign push      = iPREVIOUS_VALID & ~full & ~iFLUSH;
  assign pop       = not_empty & ~iNEXT_LOCK & ~iFLUSH;

  // Combinational shifter. One guard bit beside the operand catches the carry-out,
  // which also gives the right CF for amounts of 0, 32 and above 32.
  always_comb begin
    amt     = iPREVIOUS_DATA_1[5:0];
    rot     = amt[4:0];
    sll_w   = {1'b0, iPREVIOUS_DATA_0} << amt;
    srl_w   = {iPREVIOUS_DATA_0, 1'b0} >> amt;
    sra_w   = $signed({iPREVIOUS_DATA_0, 1'b0}) >>> amt;
    rol_res = (iPREVIOUS_DATA_0 << rot) | (iPREVIOUS_DATA_0 >> (6'd32 - {1'b0, rot}));
    ror_res = (iPREVIOUS_DATA_0 >> rot) | (iPREVIOUS_DATA_0 << (6'd32 - {1'b0, rot}));
    sh_res  = iPREVIOUS_DATA_0;
    sh_cf   = 1'b0;
    case (iPREVIOUS_CMD)
      3'd1: begin sh_res = sll_w[31:0];  sh_cf = sll_w[32]; end
      3'd2: begin sh_res = srl_w[32:1];  sh_cf = srl_w[0];  end
      3'd3: begin sh_res = sra_w[32:1];  sh_cf = sra_w[0];  end
      3'd4: begin sh_res = rol_res;      sh_cf = sll_w[32]; end
      3'd5: begin sh_res = ror_res;      sh_cf = srl_w[0];  end
      default: ;
    endcase
    sh_flags = {sh_res[31], 1'b0, sh_cf, sh_res[0], (sh_res == 32'd0)};
  end

  // Occupancy next state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and architectural flags
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= 4'd0;
      flags_commit_q <= 5'd0;
    end else if (iFLUSH) begin
      // Flush drops queued work but keeps the committed flags.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (fw_q[rd_ptr_q]) begin
          flags_commit_q <= flags_q[rd_ptr_q];
        end
      end
      count_q <= count_d;
    end
  end

  // Entry storage write on push
  always_ff @(posedge iCLOCK) begin
    if (push && !iRESET_SYNC) begin
      data_q[wr_ptr_q]  <= sh_res;
      dest_q[wr_ptr_q]  <= iPREVIOUS_DESTINATION;
      flags_q[wr_ptr_q] <= sh_flags;
      fw_q[wr_ptr_q]    <= iPREVIOUS_FLAG_WRITE;
    end
  end

  // Head outputs are forced to zero while empty so stale slots never leak out.
  assign oPREVIOUS_LOCK    = full;
  assign oNEXT_VALID       = not_empty;
  assign oNEXT_DATA        = not_empty ? data_q[rd_ptr_q]  : '0;
  assign oNEXT_DESTINATION = not_empty ? dest_q[rd_ptr_q]  : '0;
  assign oNEXT_FLAGS       = not_empty ? flags_q[rd_ptr_q] : '0;
  assign oNEXT_FLAG_WRITE  = not_empty ? fw_q[rd_ptr_q]    : 1'b0;
  assign oFLAGS_COMMIT     = flags_commit_q;
  assign oCOUNT            = count_q;

endmodule

// File: tb/tb_shift_stage_buffer.sv
// Bench for shift_stage_buffer: a DEPTH=2 and a DEPTH=3 instance share the same
// stimulus and are both tracked by a queue-based reference model every cycle.
module tb_shift_stage_buffer;
  localparam int unsigned DEST_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, pv, nlock, fw;
  logic [2:0] cmd;
  logic [31:0] d0, d1;
  logic [DEST_W-1:0] dest;

  logic lock2, nv2, nfw2, lock3, nv3, nfw3;
  logic [31:0] nd2, nd3;
  logic [4:0] ndest2, ndest3, nf2, nf3, fc2, fc3;
  logic [3:0] cnt2, cnt3;

  shift_stage_buffer #(.DEPTH(2), .DEST_W(DEST_W)) dut2 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
    .iPREVIOUS_VALID(pv), .oPREVIOUS_LOCK(lock2), .iPREVIOUS_CMD(cmd),
    .iPREVIOUS_DATA_0(d0), .iPREVIOUS_DATA_1(d1), .iPREVIOUS_DESTINATION(dest),
    .iPREVIOUS_FLAG_WRITE(fw), .oNEXT_VALID(nv2), .iNEXT_LOCK(nlock),
    .oNEXT_DATA(nd2), .oNEXT_DESTINATION(ndest2), .oNEXT_FLAGS(nf2),
    .oNEXT_FLAG_WRITE(nfw2), .oFLAGS_COMMIT(fc2), .oCOUNT(cnt2)
  );

  shift_stage_buffer #(.DEPTH(3), .DEST_W(DEST_W)) dut3 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
    .iPREVIOUS_VALID(pv), .oPREVIOUS_LOCK(lock3), .iPREVIOUS_CMD(cmd),
    .iPREVIOUS_DATA_0(d0), .iPREVIOUS_DATA_1(d1), .iPREVIOUS_DESTINATION(dest),
    .iPREVIOUS_FLAG_WRITE(fw), .oNEXT_VALID(nv3), .iNEXT_LOCK(nlock),
    .oNEXT_DATA(nd3), .oNEXT_DESTINATION(ndest3), .oNEXT_FLAGS(nf3),
    .oNEXT_FLAG_WRITE(nfw3), .oFLAGS_COMMIT(fc3), .oCOUNT(cnt3)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic [4:0]  flags;
    logic        fw;
  } ent_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  ent_t mq [2][$];
  logic [4:0] mcommit [2];
  int total = 0;
  int bad = 0;
  vec_t tv [12];

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // Reference shifter: one bit position per loop step, tracking the last bit out.
  function automatic ent_t model_entry(input logic [2:0] c, input logic [31:0] a0,
                                       input logic [31:0] a1, input logic [4:0] ds,
                                       input logic f);
    ent_t e;
    logic [31:0] r, t;
    logic cf;
    int n;
    n = int'(a1[5:0]);
    r = a0;
    t = a0;
    cf = 1'b0;
    if (c == 3'd1 || c == 3'd4) begin
      for (int i = 0; i < n; i++) begin cf = t[31]; t = t << 1; end
      if (c == 3'd1) r = t;
      else for (int i = 0; i < n % 32; i++) r = {r[30:0], r[31]};
    end else if (c == 3'd2 || c == 3'd5) begin
      for (int i = 0; i < n; i++) begin cf = t[0]; t = t >> 1; end
      if (c == 3'd2) r = t;
      else for (int i = 0; i < n % 32; i++) r = {r[0], r[31:1]};
    end else if (c == 3'd3) begin
      for (int i = 0; i < n; i++) begin cf = t[0]; t = {t[31], t[31:1]}; end
      r = t;
    end
    e.data  = r;
    e.dest  = ds;
    e.flags = {r[31], 1'b0, cf, r[0], (r == 32'd0)};
    e.fw    = f;
    return e;
  endfunction

  task automatic chk(input string name, input int dep, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s depth=%0d got=%h want=%h", name, dep, got, exp);
    end
  endtask

  task automatic check_one(input int k);
    logic gv, glock, gfw;
    logic [31:0] gd;
    logic [4:0] gdest, gf, gc;
    logic [3:0] gcnt;
    ent_t h;
    int dep;
    dep = depth_of(k);
    if (k == 0) begin
      gv = nv2; glock = lock2; gfw = nfw2; gd = nd2; gdest = ndest2; gf = nf2; gc = fc2;
      gcnt = cnt2;
    end else begin
      gv = nv3; glock = lock3; gfw = nfw3; gd = nd3; gdest = ndest3; gf = nf3; gc = fc3;
      gcnt = cnt3;
    end
    h = (mq[k].size() > 0) ? mq[k][0] : '0;
    chk("next_valid", dep, gv, mq[k].size() != 0);
    chk("prev_lock", dep, glock, mq[k].size() == dep);
    chk("count", dep, gcnt, mq[k].size());
    chk("next_data", dep, gd, h.data);
    chk("next_dest", dep, gdest, h.dest);
    chk("next_flags", dep, gf, h.flags);
    chk("next_fw", dep, gfw, h.fw);
    chk("flags_commit", dep, gc, mcommit[k]);
  endtask

  // One clock: predict handshakes from pre-edge model state, advance, compare.
  task automatic tick();
    bit pe [2];
    bit pp [2];
    ent_t ne;
    ne = model_entry(cmd, d0, d1, dest, fw);
    for (int k = 0; k < 2; k++) begin
      pe[k] = pv && !flush && (mq[k].size() < depth_of(k));
      pp[k] = (mq[k].size() > 0) && !nlock && !flush;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mcommit[k] = 5'd0;
      end else if (flush) begin
        mq[k].delete();
      end else begin
        if (pp[k]) begin
          if (mq[k][0].fw) mcommit[k] = mq[k][0].flags;
          void'(mq[k].pop_front());
        end
        if (pe[k]) mq[k].push_back(ne);
      end
    end
    #1;
    check_one(0);
    check_one(1);
  endtask

  task automatic load_vec(input int i);
    cmd = tv[i].cmd;
    d0  = tv[i].d0;
    d1  = tv[i].d1;
  endtask

  task automatic rand_cmd();
    logic [5:0] a;
    cmd = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       d0 = 32'h8000_0000;
      1:       d0 = 32'h0000_0001;
      default: d0 = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0:       a = 6'd0;
      1:       a = 6'd1;
      2:       a = 6'd31;
      3:       a = 6'd32;
      4:       a = 6'd33;
      default: a = 6'($urandom_range(0, 63));
    endcase
    d1   = ($urandom & 32'hFFFF_FFC0) | {26'd0, a};
    dest = 5'($urandom_range(0, 31));
    fw   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_flush();
    flush = 1'b1; pv = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    tv[0]  = '{3'd1, 32'h8000_0001, 32'd1,  32'h0000_0002, 5'b00100};
    tv[1]  = '{3'd3, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 5'b10110};
    tv[2]  = '{3'd5, 32'h0000_0001, 32'd33, 32'h8000_0000, 5'b10000};
    tv[3]  = '{3'd2, 32'h0000_0001, 32'd1,  32'h0000_0000, 5'b00101};
    tv[4]  = '{3'd1, 32'h0000_0001, 32'd32, 32'h0000_0000, 5'b00101};
    tv[5]  = '{3'd2, 32'h8000_0000, 32'd32, 32'h0000_0000, 5'b00101};
    tv[6]  = '{3'd0, 32'h1234_5678, 32'd5,  32'h1234_5678, 5'b00000};
    tv[7]  = '{3'd7, 32'hFFFF_FFFF, 32'd9,  32'hFFFF_FFFF, 5'b10010};
    tv[8]  = '{3'd4, 32'h8000_0000, 32'd1,  32'h0000_0001, 5'b00110};
    tv[9]  = '{3'd1, 32'h1234_5678, 32'd0,  32'h1234_5678, 5'b00000};
    tv[10] = '{3'd3, 32'h4000_0000, 32'd31, 32'h0000_0000, 5'b00101};
    tv[11] = '{3'd1, 32'hFFFF_FFFF, 32'd33, 32'h0000_0000, 5'b00001};

    rst = 1'b1; flush = 1'b0; pv = 1'b0; nlock = 1'b0; fw = 1'b0;
    cmd = 3'd0; d0 = 32'd0; d1 = 32'd0; dest = '0;
    mcommit[0] = 5'd0; mcommit[1] = 5'd0;
    #2;
    tick();
    tick();
    rst = 1'b0;
    tick();
    // Reset then idle
    chk("rst_valid", 2, nv2, 1'b0);
    chk("rst_lock", 2, lock2, 1'b0);
    chk("rst_count", 2, cnt2, 4'd0);
    chk("rst_commit", 2, fc2, 5'h00);
    chk("rst_count", 3, cnt3, 4'd0);

    // Table: one command at a time, held at the head, then popped with fw=1
    for (int i = 0; i < 12; i++) begin
      load_vec(i);
      dest = 5'(i); fw = 1'b1; nlock = 1'b1; pv = 1'b1;
      tick();
      pv = 1'b0;
      chk("tv_data", 2, nd2, tv[i].res);
      chk("tv_flags", 2, nf2, tv[i].flags);
      chk("tv_dest", 2, ndest2, 5'(i));
      chk("tv_data", 3, nd3, tv[i].res);
      nlock = 1'b0;
      tick();
      chk("tv_commit", 2, fc2, tv[i].flags);
      chk("tv_drained", 2, cnt2, 4'd0);
    end

    // Fill with downstream stalled; third command held until space frees
    do_flush();
    nlock = 1'b1; fw = 1'b1; pv = 1'b1;
    load_vec(0); tick();
    load_vec(1); tick();
    load_vec(2); tick();
    chk("full_count", 2, cnt2, 4'd2);
    chk("full_lock", 2, lock2, 1'b1);
    chk("full_head", 2, nd2, tv[0].res);
    nlock = 1'b0;
    tick();
    chk("nobypass_count", 2, cnt2, 4'd1);
    chk("nobypass_lock", 2, lock2, 1'b0);
    chk("nobypass_head", 2, nd2, tv[1].res);
    tick();
    chk("late_push_count", 2, cnt2, 4'd1);
    chk("late_push_head", 2, nd2, tv[2].res);
    chk("late_push_commit", 2, fc2, tv[1].flags);
    pv = 1'b0;
    tick();
    chk("drain_count", 2, cnt2, 4'd0);
    chk("drain_commit", 2, fc2, tv[2].flags);

    // Flush with a pop and a push pending
    do_flush();
    nlock = 1'b1; pv = 1'b1;
    load_vec(3); tick();
    load_vec(4); tick();
    flush = 1'b1; nlock = 1'b0;
    load_vec(5);
    tick();
    flush = 1'b0; pv = 1'b0;
    chk("flush_count", 2, cnt2, 4'd0);
    chk("flush_valid", 2, nv2, 1'b0);
    chk("flush_commit", 2, fc2, tv[2].flags);
    chk("flush_count", 3, cnt3, 4'd0);

    // Steady push+pop: occupancy of the DEPTH=3 instance stays at 2 while pointers wrap
    nlock = 1'b1; pv = 1'b1;
    rand_cmd(); tick();
    rand_cmd(); tick();
    nlock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_cmd();
      tick();
      chk("steady_count", 3, cnt3, 4'd2);
    end
    pv = 1'b0;

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if (!(pv && (mq[0].size() == 2 || mq[1].size() == 3))) begin
        rand_cmd();
        pv = ($urandom_range(0, 3) != 0);
      end
      nlock = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 96) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; pv = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
